mealy_stream_ctrl: RTL and testbench
====================================

Name: mealy_stream_ctrl

Overview:
Byte-to-bit sequencer and result collector for the serial Mealy sequence detector in the tt_um_islam_ihfaz_mealy design. It accepts a byte via valid/ready and shifts it MSB-first into the detector, one bit per enabled cycle. Each cycle it samples the detector's combinational match output, then returns a per-bit match map and a match count via valid/ready. It sits between the pin-level I/O glue and the detector core.

Parameters:
DATA_W, 8, bits per input word; also the number of SHIFT cycles per word
CNT_W, 4, match counter width; the counter saturates at 2^CNT_W-1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; low freezes all state
cfg_clr_each  input  1  1: clear the detector at each word accept; 0: detector history carries across words
in_data  input  DATA_W  word to serialise
in_valid  input  1  in_data valid
in_ready  output  1  controller can accept a word
det_en  output  1  detector advances this cycle
det_bit  output  1  serial bit to detector
det_clr  output  1  one-cycle synchronous clear to detector
det_match  input  1  detector Mealy output for the current det_bit (combinational)
out_map  output  DATA_W  bit i set = match when in_data[i] was shifted
out_cnt  output  CNT_W  number of matches in the word
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result

Behaviour:
- Reset is asynchronous, active-low, and mid-operation reset is allowed. On reset: state=IDLE, in_ready=0 during reset and 1 after release, det_en=0, det_bit=0, det_clr=0, out_valid=0, out_map=0, out_cnt=0, bit index=0, shift register=0. An in-flight word is discarded.
- ena=0: no state, register, or handshake change. in_ready and out_valid are forced low. det_en, det_clr=0.
- FSM states are IDLE, SHIFT and REPORT. All transitions below require ena=1.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load the shift register with in_data, set idx=DATA_W-1, clear map and count.
  - det_clr=cfg_clr_each in that same accept cycle (combinational, accept cycle only).
  - Go to SHIFT.
- SHIFT:
  - in_ready=0, det_en=1, det_bit=sreg[DATA_W-1].
  - Each cycle: map[idx]<=det_match; cnt<=sat(cnt+det_match); shift sreg left (zero fill); idx decrements.
  - After the cycle with idx=0, go to REPORT.
  - Exactly DATA_W SHIFT cycles per word.
- REPORT:
  - out_valid=1; out_map and out_cnt are stable while out_valid=1 and out_ready=0.
  - On out_ready=1: go to IDLE.
  - out_valid and in_ready are never high together, so a word is not accepted in the REPORT-exit cycle. It is accepted on the next IDLE cycle.
- Latency: accept at cycle T → det_en high T+1..T+DATA_W → out_valid first high T+DATA_W+1. Back-to-back throughput is one word per DATA_W+2 cycles with out_ready held high.
- det_match is ignored whenever det_en=0.
- Saturation: cnt stops at 2^CNT_W-1. Width rule: cnt+1 is computed in CNT_W+1 bits, then clamped.
- in_valid held during SHIFT/REPORT is not consumed. in_data is sampled only at accept.

Decomposition:
- Package mealy_ctrl_pkg: FSM state enum (IDLE, SHIFT, REPORT), DATA_W/CNT_W defaults, and a saturating-increment function.
- One sub-module, mealy_bit_serializer: load/shift register plus down-counter, with outputs bit, last and idx. The FSM, handshake, map and count stay in the top.

Test Plan:
The bench detector model asserts det_match when the last three bits, including the current bit, are 1,0,1 (overlapping). It clears on det_clr.
1. Reset mid-SHIFT (after 3 det_en pulses): rst_n low → all outputs 0 immediately; after release in_ready=1 and the next word is processed from scratch.
2. cfg_clr_each=1, in_data=0xAA, out_ready=1 → det_clr pulse at accept, 8 det_en cycles, out_map=0x2A, out_cnt=3, out_valid at accept+9.
3. cfg_clr_each=0, words 0xAA then 0x80 → second result out_map=0x80, out_cnt=1 (history carried). Same sequence with cfg_clr_each=1 → second result 0x00, 0.
4. out_ready held low 5 cycles in REPORT → out_valid stays 1, map/count stable, in_ready=0, in_valid ignored. Releasing out_ready → IDLE next cycle.
5. ena dropped for 4 cycles mid-SHIFT → det_en=0 and idx frozen. After ena returns, 0xAA still yields 0x2A/3 with total SHIFT det_en pulses=8.
6. CNT_W=1, in_data=0xAA → out_cnt saturates at 1, out_map=0x2A.

Source files
------------

// File: rtl/mealy_ctrl_pkg.sv
// mealy_ctrl_pkg
// Shared definitions for the Mealy stream controller:
//   - default word and match-counter widths
//   - FSM state encoding (IDLE, SHIFT, REPORT)
//   - sat_inc: saturating increment for counters up to 16 bits wide
package mealy_ctrl_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      REPORT = 2'd2
   } state_e;

   // Adds inc to cnt, clamping at 2^w-1. The sum is formed one bit wider
   // than the counter so the carry out is visible before the clamp.
   function automatic logic [15:0] sat_inc(input logic [15:0] cnt,
                                           input logic        inc,
                                           input int unsigned w);
      logic [16:0] sum;
      logic [16:0] lim;
      sum = {1'b0, cnt} + {16'd0, inc};
      lim = (17'd1 << w) - 17'd1;
      if (sum > lim) begin
         return lim[15:0];
      end else begin
         return sum[15:0];
      end
   endfunction

endpackage

// File: rtl/mealy_bit_serializer.sv
// mealy_bit_serializer
// Load/shift register with a matching down-counter. A word is loaded in
// one cycle and then presented MSB-first, one bit per shift cycle.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture load_data, set idx to DATA_W-1
//   shift       : shift left (zero fill), decrement idx
//   load_data   : word to serialise
//   bit_o       : current serial bit (register MSB)
//   last        : idx is 0, i.e. the current bit is the final one
//   idx         : position in the original word of the current bit
module mealy_bit_serializer
   import mealy_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] load_data,
   output logic              bit_o,
   output logic              last,
   output logic [IDX_W-1:0]  idx
);

   logic [DATA_W-1:0] sreg_q, sreg_d;
   logic [IDX_W-1:0]  idx_q, idx_d;

   always_comb begin
      sreg_d = sreg_q;
      idx_d  = idx_q;
      if (load) begin
         sreg_d = load_data;
         idx_d  = IDX_W'(DATA_W - 1);
      end else if (shift) begin
         sreg_d = sreg_q << 1;
         idx_d  = idx_q - IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q <= '0;
         idx_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         idx_q  <= idx_d;
      end
   end

   assign bit_o = sreg_q[DATA_W-1];
   assign last  = (idx_q == '0);
   assign idx   = idx_q;

endmodule

// File: rtl/mealy_stream_ctrl.sv
// mealy_stream_ctrl
// Takes a word over valid/ready, shifts it MSB-first into an external
// Mealy sequence detector, samples the detector's combinational match
// each shift cycle, and returns a per-bit match map plus a saturating
// match count over valid/ready.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   ena            : global enable; low freezes everything and drops
//                    in_ready/out_valid/det_en/det_clr
//   cfg_clr_each   : clear the detector when a word is accepted
//   in_data/in_valid/in_ready    : input word handshake
//   det_en/det_bit/det_clr       : detector drive
//   det_match                    : detector output for current det_bit
//   out_map/out_cnt/out_valid/out_ready : result handshake
//   dbg_state      : current FSM state
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high while ena is high; valid never depends on ready. in_ready and
// out_valid are never high together, so a result must be taken before
// the next word is accepted.
module mealy_stream_ctrl
   import mealy_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              cfg_clr_each,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              det_en,
   output logic              det_bit,
   output logic              det_clr,
   input  logic              det_match,
   output logic [DATA_W-1:0] out_map,
   output logic [CNT_W-1:0]  out_cnt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        dbg_state
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_SHIFT  = SHIFT;
   localparam logic [1:0] ST_REPORT = REPORT;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] map_q, map_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   // Low only while reset is applied, so in_ready stays low in reset even
   // though the FSM already sits in IDLE.
   logic              alive_q;

   logic              accept;
   logic              ser_load, ser_shift, ser_bit, ser_last;
   logic [IDX_W-1:0]  ser_idx;

   mealy_bit_serializer #(.DATA_W(DATA_W)) u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (ser_load),
      .shift     (ser_shift),
      .load_data (in_data),
      .bit_o     (ser_bit),
      .last      (ser_last),
      .idx       (ser_idx)
   );

   assign in_ready  = ena & alive_q & (state_q == ST_IDLE);
   assign accept    = in_valid & in_ready;
   assign det_clr   = accept & cfg_clr_each;
   assign det_en    = ena & (state_q == ST_SHIFT);
   assign det_bit   = (state_q == ST_SHIFT) & ser_bit;
   assign out_valid = ena & (state_q == ST_REPORT);
   assign out_map   = map_q;
   assign out_cnt   = cnt_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d   = state_q;
      map_d     = map_q;
      cnt_d     = cnt_q;
      ser_load  = 1'b0;
      ser_shift = 1'b0;
      if (ena) begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  ser_load = 1'b1;
                  map_d    = '0;
                  cnt_d    = '0;
                  state_d  = ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               ser_shift      = 1'b1;
               map_d[ser_idx] = det_match;
               cnt_d          = CNT_W'(sat_inc(16'(cnt_q), det_match, CNT_W));
               if (ser_last) begin
                  state_d = ST_REPORT;
               end
            end
            ST_REPORT: begin
               if (out_ready) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         map_q   <= '0;
         cnt_q   <= '0;
         alive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         map_q   <= map_d;
         cnt_q   <= cnt_d;
         alive_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mealy_stream_ctrl.sv
// tb_mealy_stream_ctrl
// Directed bench for mealy_stream_ctrl. Two instances share the inputs:
// dut_a with CNT_W=4 and dut_b with CNT_W=1 (saturating counter). Each
// has its own 1,0,1 overlapping detector model.
module tb_mealy_stream_ctrl;

   localparam int DATA_W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic              ena;
   logic              cfg_clr_each;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              out_ready;

   logic              in_ready_a, det_en_a, det_bit_a, det_clr_a, det_match_a, out_valid_a;
   logic [DATA_W-1:0] out_map_a;
   logic [3:0]        out_cnt_a;
   logic [1:0]        dbg_state_a;

   logic              in_ready_b, det_en_b, det_bit_b, det_clr_b, det_match_b, out_valid_b;
   logic [DATA_W-1:0] out_map_b;
   logic [0:0]        out_cnt_b;
   logic [1:0]        dbg_state_b;

   mealy_stream_ctrl #(.DATA_W(DATA_W), .CNT_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_clr_each(cfg_clr_each),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
      .det_en(det_en_a), .det_bit(det_bit_a), .det_clr(det_clr_a),
      .det_match(det_match_a), .out_map(out_map_a), .out_cnt(out_cnt_a),
      .out_valid(out_valid_a), .out_ready(out_ready), .dbg_state(dbg_state_a)
   );

   mealy_stream_ctrl #(.DATA_W(DATA_W), .CNT_W(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .ena(ena), .cfg_clr_each(cfg_clr_each),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
      .det_en(det_en_b), .det_bit(det_bit_b), .det_clr(det_clr_b),
      .det_match(det_match_b), .out_map(out_map_b), .out_cnt(out_cnt_b),
      .out_valid(out_valid_b), .out_ready(out_ready), .dbg_state(dbg_state_b)
   );

   // Detector models: hist[0] = previous bit, hist[1] = the one before.
   logic [1:0] hist_a, hist_b;
   assign det_match_a = hist_a[1] & ~hist_a[0] & det_bit_a;
   assign det_match_b = hist_b[1] & ~hist_b[0] & det_bit_b;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_a <= 2'b00;
         hist_b <= 2'b00;
      end else begin
         if (det_clr_a)     hist_a <= 2'b00;
         else if (det_en_a) hist_a <= {hist_a[0], det_bit_a};
         if (det_clr_b)     hist_b <= 2'b00;
         else if (det_en_b) hist_b <= {hist_b[0], det_bit_b};
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int last_acc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Sends one word, follows it through SHIFT and checks the result.
   // hold    : cycles to keep out_ready low in REPORT (0 = ready at once)
   // drop_at : det_en pulse count at which ena drops for 4 cycles (-1 none)
   // chk_gap : check accept-to-accept distance against DATA_W+2
   task automatic run_word(input logic [7:0] data, input logic [7:0] exp_map,
                           input int exp_cnt, input int hold, input int drop_at,
                           input bit chk_gap);
      int  waitc, pulses, lat;
      bit  dropped, got;
      logic [7:0] map_snap;
      logic [3:0] cnt_snap;
      in_data   = data;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      waitc     = 0;
      #1;
      while (!in_ready_a && waitc < 30) begin
         tick;
         #1;
         waitc++;
      end
      if (!in_ready_a) begin
         check("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      check("det_clr_at_accept", det_clr_a, cfg_clr_each);
      if (chk_gap) check("b2b_gap", cyc - last_acc, DATA_W + 2);
      last_acc = cyc;
      tick;
      in_valid = 1'b0;
      in_data  = 8'h00;
      pulses = 0; lat = 1; dropped = 0; got = 0;
      for (int g = 0; g < 40 && !got; g++) begin
         if (drop_at >= 0 && !dropped && pulses == drop_at) begin
            ena = 1'b0;
            for (int k = 0; k < 4; k++) begin
               #1;
               check("ena_off_det_en", det_en_a, 1'b0);
               tick;
               lat++;
            end
            ena = 1'b1;
            dropped = 1;
         end
         #1;
         if (out_valid_a) begin
            got = 1;
         end else begin
            if (det_en_a) pulses++;
            tick;
            lat++;
         end
      end
      check("result_seen", got, 1'b1);
      if (!got) return;
      check("shift_pulses", pulses, DATA_W);
      check("latency", lat, (drop_at >= 0) ? DATA_W + 5 : DATA_W + 1);
      check("out_map", out_map_a, exp_map);
      check("out_cnt", out_cnt_a, exp_cnt);
      check("out_map_sat", out_map_b, exp_map);
      check("out_cnt_sat", out_cnt_b, (exp_cnt > 1) ? 1 : exp_cnt);
      check("in_ready_in_report", in_ready_a, 1'b0);
      if (hold > 0) begin
         map_snap = out_map_a;
         cnt_snap = out_cnt_a;
         in_valid = 1'b1;
         in_data  = 8'hFF;
         for (int k = 0; k < hold; k++) begin
            tick;
            #1;
            check("hold_valid", out_valid_a, 1'b1);
            check("hold_map", out_map_a, map_snap);
            check("hold_cnt", out_cnt_a, cnt_snap);
            check("hold_in_ready", in_ready_a, 1'b0);
         end
         out_ready = 1'b1;
         tick;
         in_valid = 1'b0;
         #1;
         check("idle_after_release", in_ready_a, 1'b1);
         check("no_accept_on_exit", det_en_a, 1'b0);
      end else begin
         tick;
      end
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; cfg_clr_each = 1'b1;
      in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      check("reset_outs", {in_ready_a, det_en_a, det_bit_a, det_clr_a, out_valid_a, out_map_a, out_cnt_a}, 0);
      tick; tick;
      rst_n = 1'b1;
      tick;
      #1;
      check("ready_after_reset", in_ready_a, 1'b1);

      // ena low in IDLE: no ready, no accept
      ena = 1'b0; in_valid = 1'b1; in_data = 8'h55;
      #1;
      check("ena_off_in_ready", in_ready_a, 1'b0);
      tick; tick;
      ena = 1'b1; in_valid = 1'b0;
      #1;
      check("ena_off_no_accept", {in_ready_a, det_en_a}, 2'b10);

      // Reset in the middle of SHIFT, after three det_en pulses
      in_data = 8'hFF; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick; tick; tick;
      #1;
      check("mid_shift_det_en", {det_en_a, det_bit_a}, 2'b11);
      rst_n = 1'b0;
      #1;
      check("mid_reset_outs", {in_ready_a, det_en_a, det_bit_a, det_clr_a, out_valid_a, out_map_a, out_cnt_a}, 0);
      tick; tick;
      rst_n = 1'b1;
      tick;
      #1;
      check("ready_after_mid_reset", in_ready_a, 1'b1);

      // Basic word with clear at accept
      cfg_clr_each = 1'b1;
      run_word(8'hAA, 8'h2A, 3, 0, -1, 1'b0);

      // History carried across words
      cfg_clr_each = 1'b0;
      run_word(8'hAA, 8'hAA, 4, 0, -1, 1'b1);
      run_word(8'h80, 8'h80, 1, 0, -1, 1'b1);

      // Same sequence with clear at each word
      cfg_clr_each = 1'b1;
      run_word(8'hAA, 8'h2A, 3, 0, -1, 1'b1);
      run_word(8'h80, 8'h00, 0, 0, -1, 1'b1);

      // Back-pressure in REPORT
      run_word(8'hAA, 8'h2A, 3, 5, -1, 1'b0);

      // ena dropped mid-SHIFT
      run_word(8'hAA, 8'h2A, 3, 0, 3, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
